// File: rtl/rv32i_pkg.sv
//------------------------------------------------------------------------------
// rv32i_pkg : shared RV32I constants and register-file state encoding
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

endpackage

`default_nettype wire

// File: rtl/reg_file_rv32i.sv
//------------------------------------------------------------------------------
// reg_file_rv32i : 32-entry integer register file, 2 async reads, 1 write
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_rv32i
  import rv32i_pkg::*;
#(
  parameter int n        = rv32i_pkg::XLEN,
  parameter int NUM_REGS = rv32i_pkg::NUM_REGS,
  parameter int ADDR_W   = rv32i_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [n-1:0]      rd_data,
  input  logic              reg_write,
  output logic [n-1:0]      op1,
  output logic [n-1:0]      op2,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              busy_q, busy_d;

  logic [n-1:0]      mem_q [NUM_REGS];

  logic              sweep_we;
  logic              user_we;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [n-1:0]      wr_data;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    if (state_q == RF_CLEAR) begin
      if (clr_idx_q == LAST_IDX) begin
        clr_idx_d = '0;
        state_d   = RF_READY;
        busy_d    = 1'b0;
      end else begin
        clr_idx_d = clr_idx_q + 1'b1;
      end
    end
  end

  // busy is kept as its own flop so the stall output is a clean register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  assign sweep_we = rst_n && (state_q == RF_CLEAR);
  assign user_we  = rst_n && (state_q == RF_READY) && reg_write && (rd_addr != X0);
  assign wr_en    = sweep_we || user_we;
  assign wr_addr  = sweep_we ? clr_idx_q : rd_addr;
  assign wr_data  = sweep_we ? '0 : rd_data;

  // No reset on the array so it maps onto plain RAM; the sweep clears it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // No write-through bypass: a same-cycle write is visible only next cycle.
  assign op1  = (busy_q || rs1_addr == X0) ? '0 : mem_q[rs1_addr];
  assign op2  = (busy_q || rs2_addr == X0) ? '0 : mem_q[rs2_addr];
  assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_rv32i.sv
//------------------------------------------------------------------------------
// tb_reg_file_rv32i : scoreboard bench for reg_file_rv32i
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_rv32i;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data = '0;
  logic        reg_write = 1'b0;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  logic [31:0] model [32];

  reg_file_rv32i dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .reg_write (reg_write),
    .op1       (op1),
    .op2       (op2),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_read(input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2);
    rs1_addr = a1;
    rs2_addr = a2;
    q1.push_back(e1);
    q2.push_back(e2);
  endtask

  task automatic test_reset();
    logic [31:0] e1, e2;
    rst_n = 1'b0;
    reg_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      push_read(5'd1, 5'd2, 32'h0, 32'h0);
      #1;
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL reset_busy got=%b want=1", busy);
      end
      checks++;
      if (op1 !== e1) begin
        failures++;
        $display("FAIL reset_op1 got=%h want=%h", op1, e1);
      end
      checks++;
      if (op2 !== e2) begin
        failures++;
        $display("FAIL reset_op2 got=%h want=%h", op2, e2);
      end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] e1, e2;
    rst_n = 1'b1;
    reg_write = 1'b1;
    rd_addr = 5'd5;
    rd_data = 32'hDEADBEEF;
    for (int k = 0; k < 32; k++) begin
      push_read(5'd5, 5'(k), 32'h0, 32'h0);
      #1;
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL sweep_busy cycle=%0d got=%b want=1", k, busy);
      end
      checks++;
      if (op1 !== e1 || op2 !== e2) begin
        failures++;
        $display("FAIL sweep_ops cycle=%0d got=%h/%h want=%h/%h", k, op1, op2, e1, e2);
      end
      tick();
    end
    reg_write = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL sweep_done got=%b want=0", busy);
    end
    for (int r = 0; r < 32; r++) model[r] = 32'h0;
    for (int r = 0; r < 32; r++) begin
      push_read(5'(r), 5'(31 - r), model[r], model[31 - r]);
      #1;
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      checks++;
      if (op1 !== e1 || op2 !== e2) begin
        failures++;
        $display("FAIL cleared_read r=%0d got=%h/%h want=%h/%h", r, op1, op2, e1, e2);
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    logic [31:0] e1, e2, val;
    rd_addr = 5'd7;
    rd_data = 32'h1234_5678;
    reg_write = 1'b1;
    tick();
    model[7] = 32'h1234_5678;
    reg_write = 1'b0;
    push_read(5'd7, 5'd7, model[7], model[7]);
    #1;
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    checks++;
    if (op1 !== e1 || op2 !== e2) begin
      failures++;
      $display("FAIL write_x7 got=%h/%h want=%h/%h", op1, op2, e1, e2);
    end
    // Write r while reading r-1 (written last cycle) and r (old value).
    for (int r = 1; r < 32; r++) begin
      val = $urandom();
      rd_addr = 5'(r);
      rd_data = val;
      reg_write = 1'b1;
      push_read(5'(r - 1), 5'(r), model[r - 1], model[r]);
      #1;
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      checks++;
      if (op1 !== e1 || op2 !== e2) begin
        failures++;
        $display("FAIL walk_write r=%0d got=%h/%h want=%h/%h", r, op1, op2, e1, e2);
      end
      model[r] = val;
      tick();
    end
    reg_write = 1'b0;
    push_read(5'd31, 5'd16, model[31], model[16]);
    #1;
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    checks++;
    if (op1 !== e1 || op2 !== e2) begin
      failures++;
      $display("FAIL walk_final got=%h/%h want=%h/%h", op1, op2, e1, e2);
    end
  endtask

  task automatic test_x0();
    logic [31:0] e1, e2;
    rd_addr = 5'd0;
    rd_data = 32'hFFFF_FFFF;
    reg_write = 1'b1;
    push_read(5'd0, 5'd0, 32'h0, 32'h0);
    #1;
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    checks++;
    if (op1 !== e1 || op2 !== e2) begin
      failures++;
      $display("FAIL x0_same_cycle got=%h/%h want=%h/%h", op1, op2, e1, e2);
    end
    tick();
    reg_write = 1'b0;
    push_read(5'd0, 5'd31, 32'h0, model[31]);
    #1;
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    checks++;
    if (op1 !== e1 || op2 !== e2) begin
      failures++;
      $display("FAIL x0_after got=%h/%h want=%h/%h", op1, op2, e1, e2);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] e1, e2;
    rd_addr = 5'd3;
    rd_data = 32'hA;
    reg_write = 1'b1;
    tick();
    model[3] = 32'hA;
    rd_data = 32'hB;
    push_read(5'd3, 5'd3, model[3], model[3]);
    #1;
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    checks++;
    if (op1 !== e1 || op2 !== e2) begin
      failures++;
      $display("FAIL same_cycle_old got=%h/%h want=%h/%h", op1, op2, e1, e2);
    end
    tick();
    model[3] = 32'hB;
    reg_write = 1'b0;
    push_read(5'd3, 5'd3, model[3], model[3]);
    #1;
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    checks++;
    if (op1 !== e1 || op2 !== e2) begin
      failures++;
      $display("FAIL same_cycle_new got=%h/%h want=%h/%h", op1, op2, e1, e2);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] e1, e2;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL mid_first_busy cycle=%0d got=%b want=1", k, busy);
      end
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      #1;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL mid_restart_busy cycle=%0d got=%b want=1", k, busy);
      end
      tick();
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_restart_done got=%b want=0", busy);
    end
    for (int r = 0; r < 32; r++) model[r] = 32'h0;
    for (int r = 0; r < 32; r++) begin
      push_read(5'(r), 5'(r), model[r], model[r]);
      #1;
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      checks++;
      if (op1 !== e1 || op2 !== e2) begin
        failures++;
        $display("FAIL mid_cleared r=%0d got=%h/%h want=%h/%h", r, op1, op2, e1, e2);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_sweep();
    test_write_read();
    test_x0();
    test_same_cycle();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
